day10_solver_scheduler: RTL and testbench

Dispatches parsed day-10 machine jobs round-robin to NUM_SOLVERS parallel configure_machine lanes. Collects per-machine minimum press counts strictly in job order and accumulates the puzzle total. Sits between day10_input_reader and day10_output_writer. It replaces the single-lane read/configure/write sequencing with pipelined multi-lane scheduling.

---
 rtl/day10_sched_pkg.sv | 22 ++
 rtl/day10_rr_ptr.sv | 22 ++
 rtl/day10_solver_scheduler.sv | 148 ++++++++++++++
 tb/tb_day10_solver_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/day10_sched_pkg.sv
// Shared types for the day-10 solver scheduler: FSM states, lane pointer width, job record.
package day10_sched_pkg;

    typedef enum logic [1:0] {RUN, FLUSH, DONE} sched_state_t;

    localparam int DEF_NUM_LIGHTS  = 10;
    localparam int DEF_NUM_BUTTONS = 13;
    localparam int DEF_PRESS_WIDTH = $clog2(DEF_NUM_BUTTONS + 1);

    typedef struct packed {
        logic [DEF_NUM_LIGHTS-1:0]                 target;
        logic [DEF_NUM_BUTTONS*DEF_NUM_LIGHTS-1:0] buttons;
        logic [DEF_PRESS_WIDTH-1:0]                num_buttons;
        logic                                      last;
    } job_t;

    // A single lane still needs a one-bit pointer.
    function automatic int lane_ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/day10_rr_ptr.sv
// Wrapping modulo-N lane pointer, advanced by inc.
// Latency: new value visible the cycle after inc.
// Backpressure: none; holds its value while inc is low.
module day10_rr_ptr #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == W'(N - 1)) ? '0 : ptr + W'(1);
        end
    end

endmodule

// File: rtl/day10_solver_scheduler.sv
// Round-robin job dispatch to NUM_SOLVERS lanes, in-order result collection and total; DAY10_SCHED_SAT_EN saturates total.
// Latency: job accept -> solver_start same cycle; solver_done -> res_valid one cycle.
// Backpressure: res_ready low holds res_* and withholds acks; job_ready low while the next dispatch lane is busy.
module day10_solver_scheduler
    import day10_sched_pkg::*;
#(
    parameter int NUM_SOLVERS     = 4,
    parameter int MAX_NUM_LIGHTS  = DEF_NUM_LIGHTS,
    parameter int MAX_NUM_BUTTONS = DEF_NUM_BUTTONS,
    parameter int PRESS_WIDTH     = $clog2(MAX_NUM_BUTTONS + 1),
    parameter int SUM_WIDTH       = 32,
    parameter int IDX_WIDTH       = 16
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      job_valid,
    output logic                                      job_ready,
    input  logic [MAX_NUM_LIGHTS-1:0]                 job_target,
    input  logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0] job_buttons,
    input  logic [$clog2(MAX_NUM_BUTTONS+1)-1:0]      job_num_buttons,
    input  logic                                      job_last,
    output logic [NUM_SOLVERS-1:0]                    solver_start,
    output logic [MAX_NUM_LIGHTS-1:0]                 solver_target,
    output logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0] solver_buttons,
    output logic [$clog2(MAX_NUM_BUTTONS+1)-1:0]      solver_num_buttons,
    input  logic [NUM_SOLVERS-1:0]                    solver_done,
    input  logic [NUM_SOLVERS*PRESS_WIDTH-1:0]        solver_presses,
    output logic [NUM_SOLVERS-1:0]                    solver_ack,
    output logic                                      res_valid,
    input  logic                                      res_ready,
    output logic [PRESS_WIDTH-1:0]                    res_presses,
    output logic [IDX_WIDTH-1:0]                      res_idx,
    output logic                                      total_valid,
    output logic [SUM_WIDTH-1:0]                      total,
    output logic                                      overflow
);

    localparam int LW = lane_ptr_width(NUM_SOLVERS);

    sched_state_t           state;
    logic [NUM_SOLVERS-1:0] lane_busy;
    logic [LW-1:0]          disp_ptr, col_ptr;
    logic [IDX_WIDTH-1:0]   disp_cnt, col_cnt, last_tag;
    logic                   res_last;
    logic                   accept, collect, out_free;
    logic [PRESS_WIDTH-1:0] lane_res [NUM_SOLVERS];
    logic [PRESS_WIDTH-1:0] col_res;
    logic [SUM_WIDTH-1:0]   total_next;

    for (genvar i = 0; i < NUM_SOLVERS; i++) begin : g_lane
        assign lane_res[i] = solver_presses[i*PRESS_WIDTH +: PRESS_WIDTH];
    end

    assign job_ready          = (state == RUN) && !lane_busy[disp_ptr];
    assign accept             = job_valid && job_ready;
    assign solver_start       = accept ? (NUM_SOLVERS'(1) << disp_ptr) : '0;
    assign solver_target      = job_target;
    assign solver_buttons     = job_buttons;
    assign solver_num_buttons = job_num_buttons;

    // Only the lane at col_ptr may be collected, which keeps results in job order.
    assign out_free   = !res_valid || res_ready;
    assign col_res    = lane_res[col_ptr];
    assign collect    = lane_busy[col_ptr] && solver_done[col_ptr] && out_free;
    assign solver_ack = collect ? (NUM_SOLVERS'(1) << col_ptr) : '0;

    day10_rr_ptr #(.N(NUM_SOLVERS), .W(LW)) u_disp_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept),
        .ptr   (disp_ptr)
    );

    day10_rr_ptr #(.N(NUM_SOLVERS), .W(LW)) u_col_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (collect),
        .ptr   (col_ptr)
    );

`ifdef DAY10_SCHED_SAT_EN
    logic [SUM_WIDTH:0] sum_ext;

    assign sum_ext    = {1'b0, total} + (SUM_WIDTH + 1)'(col_res);
    assign total_next = sum_ext[SUM_WIDTH] ? '1 : sum_ext[SUM_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (collect && sum_ext[SUM_WIDTH]) begin
            overflow <= 1'b1;
        end
    end
`else
    assign total_next = total + SUM_WIDTH'(col_res);
    assign overflow   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            lane_busy   <= '0;
            disp_cnt    <= '0;
            col_cnt     <= '0;
            last_tag    <= '0;
            res_valid   <= 1'b0;
            res_presses <= '0;
            res_idx     <= '0;
            res_last    <= 1'b0;
            total       <= '0;
            total_valid <= 1'b0;
        end else begin
            lane_busy <= (lane_busy | solver_start) & ~solver_ack;
            if (accept) begin
                disp_cnt <= disp_cnt + IDX_WIDTH'(1);
                if (job_last) begin
                    last_tag <= disp_cnt;
                end
            end
            if (collect) begin
                res_valid   <= 1'b1;
                res_presses <= col_res;
                res_idx     <= col_cnt;
                res_last    <= (state == FLUSH) && (col_cnt == last_tag);
                col_cnt     <= col_cnt + IDX_WIDTH'(1);
                total       <= total_next;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
            case (state)
                RUN: begin
                    if (accept && job_last) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (res_valid && res_ready && res_last) begin
                        state       <= DONE;
                        total_valid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_day10_solver_scheduler.sv
// Bench for day10_solver_scheduler: four behavioural solver lanes, in-order scoreboard, directed and random job streams.
module tb_day10_solver_scheduler;
    import day10_sched_pkg::*;

    localparam int NS   = 4;
    localparam int NL   = DEF_NUM_LIGHTS;
    localparam int NB   = DEF_NUM_BUTTONS;
    localparam int PW   = DEF_PRESS_WIDTH;
    localparam int SW   = 4;
    localparam int IW   = 16;
    localparam int MAXT = (1 << SW) - 1;
`ifdef DAY10_SCHED_SAT_EN
    localparam int SAT = 1;
`else
    localparam int SAT = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             job_valid, job_ready, job_last;
    logic [NL-1:0]    job_target, solver_target;
    logic [NB*NL-1:0] job_buttons, solver_buttons;
    logic [PW-1:0]    job_num_buttons, solver_num_buttons;
    logic [NS-1:0]    solver_start, solver_done, solver_ack;
    logic [NS*PW-1:0] solver_presses;
    logic             res_valid, res_ready;
    logic [PW-1:0]    res_presses;
    logic [IW-1:0]    res_idx;
    logic             total_valid, overflow;
    logic [SW-1:0]    total;

    day10_solver_scheduler #(
        .NUM_SOLVERS(NS), .MAX_NUM_LIGHTS(NL), .MAX_NUM_BUTTONS(NB),
        .PRESS_WIDTH(PW), .SUM_WIDTH(SW), .IDX_WIDTH(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready), .job_target(job_target),
        .job_buttons(job_buttons), .job_num_buttons(job_num_buttons), .job_last(job_last),
        .solver_start(solver_start), .solver_target(solver_target),
        .solver_buttons(solver_buttons), .solver_num_buttons(solver_num_buttons),
        .solver_done(solver_done), .solver_presses(solver_presses), .solver_ack(solver_ack),
        .res_valid(res_valid), .res_ready(res_ready), .res_presses(res_presses), .res_idx(res_idx),
        .total_valid(total_valid), .total(total), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int n;
        int p0, p1, p2;
        int d0, d1, d2;
        int tot;
        int ovf;
    } vec_t;

    vec_t tbl [5];
    job_t jobs [64];
    int   job_p [64];
    int   job_d [64];
    int   vec  = 0;
    int   errs = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic make_job(input int i, input int p, input int d, input bit last);
        jobs[i].target = NL'($urandom);
        for (int b = 0; b < NB; b++) jobs[i].buttons[b*NL +: NL] = NL'($urandom);
        jobs[i].num_buttons = PW'($urandom_range(0, NB));
        jobs[i].last = last;
        job_p[i] = p;
        job_d[i] = d;
    endtask

    task automatic drive_job(input int i);
        job_target      = jobs[i].target;
        job_buttons     = jobs[i].buttons;
        job_num_buttons = jobs[i].num_buttons;
        job_last        = jobs[i].last;
    endtask

    function automatic int ref_total(input int n, output int ovf);
        int s;
        s = 0;
        for (int i = 0; i < n; i++) s += job_p[i];
        ovf = 0;
        if (SAT != 0 && s > MAXT) begin
            ovf = 1;
            return MAXT;
        end
        return (SAT != 0) ? s : s % (MAXT + 1);
    endfunction

    task automatic idle_inputs();
        job_valid = 1'b0; job_target = '0; job_buttons = '0; job_num_buttons = '0; job_last = 1'b0;
        solver_done = '0; solver_presses = '0; res_ready = 1'b0;
    endtask

    task automatic check_reset();
        check("rst_job_ready", job_ready, 1);
        check("rst_solver_start", solver_start, 0);
        check("rst_solver_ack", solver_ack, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_presses", res_presses, 0);
        check("rst_res_idx", res_idx, 0);
        check("rst_total_valid", total_valid, 0);
        check("rst_total", total, 0);
        check("rst_overflow", overflow, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives jobs 0..n-1, plays the solver lanes and scoreboards results in job order.
    task automatic run_stream(input int n, input int vld_pct, input int rdy_pct, input int stall,
                              input int exp_tot, input int exp_ovf, input bit abort);
        int acc, col, hs, acks_dut, cyc, c;
        bit busy_m [NS];
        bit done_d [NS];
        int lane_job [NS];
        int lane_cnt [NS];
        bit resv_m, exp_ready;
        logic [NS-1:0] exp_ack, exp_start;
        acc = 0; col = 0; hs = 0; acks_dut = 0; cyc = 0; resv_m = 0;
        for (int l = 0; l < NS; l++) begin
            busy_m[l] = 0; done_d[l] = 0; lane_job[l] = 0; lane_cnt[l] = 0;
        end
        while (hs < n && cyc < 3000) begin
            @(negedge clk);
            job_valid = (acc < n) && ($urandom_range(0, 99) < vld_pct);
            if (acc < n) drive_job(acc);
            for (int l = 0; l < NS; l++) begin
                done_d[l] = busy_m[l] && lane_cnt[l] == 0;
                solver_done[l] = done_d[l];
                solver_presses[l*PW +: PW] = busy_m[l] ? PW'(job_p[lane_job[l]]) : PW'($urandom);
            end
            res_ready = (cyc >= stall) && ($urandom_range(0, 99) < rdy_pct);
            #1;
            exp_ready = (acc < n) && !busy_m[acc % NS];
            check("job_ready", job_ready, exp_ready);
            check("total_valid_early", total_valid, 0);
            check("res_valid", res_valid, resv_m);
            if (resv_m) begin
                check("res_presses", res_presses, job_p[hs]);
                check("res_idx", res_idx, hs);
            end
            c = col % NS;
            exp_ack = (busy_m[c] && done_d[c] && (!resv_m || res_ready)) ? NS'(1) << c : '0;
            check("solver_ack", solver_ack, exp_ack);
            acks_dut += $countones(solver_ack);
            if (resv_m && res_ready) hs++;
            if (exp_ack != 0) begin
                resv_m = 1; busy_m[c] = 0; col++;
            end else if (res_ready) begin
                resv_m = 0;
            end
            for (int l = 0; l < NS; l++) if (busy_m[l] && lane_cnt[l] > 0) lane_cnt[l]--;
            exp_start = (job_valid && exp_ready) ? NS'(1) << (acc % NS) : '0;
            check("solver_start", solver_start, exp_start);
            if (exp_start != 0) begin
                check("solver_target", solver_target, jobs[acc].target);
                check("solver_buttons", solver_buttons, jobs[acc].buttons);
                check("solver_num_buttons", solver_num_buttons, jobs[acc].num_buttons);
                busy_m[acc % NS] = 1; lane_job[acc % NS] = acc; lane_cnt[acc % NS] = job_d[acc];
                acc++;
            end
            cyc++;
            if (abort && acc == n && hs >= 1) return;
        end
        if (hs < n) begin
            vec++; errs++;
            $display("FAIL stream_timeout: results %0d required %0d", hs, n);
        end
        @(negedge clk);
        job_valid = 1'b0; res_ready = 1'b0; solver_done = '0;
        #1;
        check("total_valid", total_valid, 1);
        check("total", total, exp_tot);
        check("overflow", overflow, exp_ovf);
        check("ready_in_done", job_ready, 0);
        check("res_valid_after", res_valid, 0);
        check("ack_count", acks_dut, n);
        repeat (3) @(negedge clk);
        #1;
        check("total_held", total, exp_tot);
        check("total_valid_held", total_valid, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, t, o, n;
        rst_n = 1'b0;
        idle_inputs();

        tbl[0] = '{1, 3, 0, 0, 4, 0, 0, 3, 0};
        tbl[1] = '{3, 2, 5, 7, 8, 5, 2, 14, 0};
        tbl[2] = '{2, 9, 9, 0, 1, 1, 0, (SAT != 0) ? 15 : 2, SAT};
        tbl[3] = '{3, 13, 0, 1, 0, 3, 0, 14, 0};
        tbl[4] = '{3, 13, 13, 13, 2, 2, 2, (SAT != 0) ? 15 : 7, SAT};

        for (int v = 0; v < 5; v++) begin
            do_reset();
            make_job(0, tbl[v].p0, tbl[v].d0, tbl[v].n == 1);
            make_job(1, tbl[v].p1, tbl[v].d1, tbl[v].n == 2);
            make_job(2, tbl[v].p2, tbl[v].d2, tbl[v].n == 3);
            run_stream(tbl[v].n, 100, 100, 0, tbl[v].tot, tbl[v].ovf, 1'b0);
        end

        // Six jobs into four stalled lanes: dispatch stops at lane 0 until it is acked.
        do_reset();
        for (int i = 0; i < 6; i++) make_job(i, 0, 0, 1'b0);
        res_ready = 1'b1;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            job_valid = 1'b1;
            drive_job(acc);
            #1;
            if (job_ready) begin
                check("stall_start", solver_start, NS'(1) << acc);
                acc++;
            end
        end
        check("stall_accepts", acc, 4);
        check("stall_ready", job_ready, 0);
        @(negedge clk);
        solver_done = 4'b0001;
        solver_presses[0 +: PW] = 4'd3;
        #1;
        check("stall_ack", solver_ack, 4'b0001);
        check("stall_no_start", solver_start, 0);
        @(negedge clk);
        solver_done = '0;
        #1;
        check("fifth_start", solver_start, 4'b0001);
        check("fifth_target", solver_target, jobs[4].target);
        check("stall_res_valid", res_valid, 1);
        check("stall_res_presses", res_presses, 3);
        check("stall_res_idx", res_idx, 0);

        // All lanes done while res_ready is held low for ten cycles.
        do_reset();
        for (int i = 0; i < 4; i++) make_job(i, $urandom_range(0, 13), 0, i == 3);
        t = ref_total(4, o);
        run_stream(4, 100, 100, 10, t, o, 1'b0);

        // Reset asserted asynchronously in FLUSH, then a fresh two-job stream.
        do_reset();
        make_job(0, 6, 1, 1'b0);
        make_job(1, 4, 15, 1'b0);
        make_job(2, 5, 15, 1'b1);
        run_stream(3, 100, 100, 0, 0, 0, 1'b1);
        @(negedge clk);
        job_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;
        make_job(0, 4, 3, 1'b0);
        make_job(1, 7, 0, 1'b1);
        run_stream(2, 100, 100, 0, 11, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            do_reset();
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) make_job(i, $urandom_range(0, 13), $urandom_range(0, 12), i == n - 1);
            t = ref_total(n, o);
            run_stream(n, $urandom_range(40, 100), $urandom_range(30, 100), $urandom_range(0, 5), t, o, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
